// File: rtl/dequeue_scheduler_v0_1.sv
// Dequeue-side scheduler: round-robin selection of an eligible output queue,
// one PIFO pop, then a held buffer read enable until EOP or timeout.
module dequeue_scheduler_v0_1 #(
    parameter int QUEUE_NUM      = 5,
    parameter int QID_WIDTH      = 3,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                 axis_aclk,
    input  logic                 axis_resetn,
    input  logic [QUEUE_NUM-1:0] s_axis_pifo_empty,
    input  logic [QUEUE_NUM-1:0] s_axis_tx_ready,
    input  logic                 s_axis_buffer_rd_valid,
    input  logic                 s_axis_buffer_rd_last,
    output logic [QUEUE_NUM-1:0] m_axis_ctl_pifo_out_en,
    output logic [QUEUE_NUM-1:0] m_axis_ctl_buffer_rd_en,
    output logic [QID_WIDTH-1:0] m_axis_grant_id,
    output logic                 m_axis_busy,
    output logic                 m_axis_err_timeout,
    output logic [31:0]          m_axis_pkt_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        READ = 2'd2
    } state_t;

    localparam int              TW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]   TO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [QID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [QID_WIDTH-1:0]   grant_q, grant_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic [QUEUE_NUM-1:0]   pifo_out_en_q, pifo_out_en_d;
    logic [QUEUE_NUM-1:0]   rd_en_q, rd_en_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic [31:0]            pkt_count_q, pkt_count_d;

    logic [QUEUE_NUM-1:0]   eligible_s;
    logic [QID_WIDTH:0]     pick_s;
    logic [QID_WIDTH-1:0]   next_ptr_s;
    logic                   eop_s;

    // Returns {found, index}; iterating downward lets the smallest offset from ptr win.
    function automatic logic [QID_WIDTH:0] rr_pick(input logic [QUEUE_NUM-1:0] elig,
                                                   input logic [QID_WIDTH-1:0] ptr);
        logic [QID_WIDTH:0] res;
        int                 idx;
        res = '0;
        for (int i = QUEUE_NUM - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % QUEUE_NUM;
            if (elig[idx]) begin
                res = {1'b1, QID_WIDTH'(idx)};
            end
        end
        return res;
    endfunction

    function automatic logic [QUEUE_NUM-1:0] onehot(input logic [QID_WIDTH-1:0] id);
        return QUEUE_NUM'(1) << id;
    endfunction

    assign eligible_s = ~s_axis_pifo_empty & s_axis_tx_ready;
    assign pick_s     = rr_pick(eligible_s, rr_ptr_q);
    assign eop_s      = s_axis_buffer_rd_valid & s_axis_buffer_rd_last;
    assign next_ptr_s = (grant_q == QID_WIDTH'(QUEUE_NUM - 1)) ? '0 : grant_q + QID_WIDTH'(1);

    // Next-state and next-output logic for the IDLE/POP/READ sequence.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        to_cnt_d      = to_cnt_q;
        pifo_out_en_d = '0;
        rd_en_d       = '0;
        err_d         = 1'b0;
        pkt_count_d   = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (pick_s[QID_WIDTH]) begin
                    grant_d       = pick_s[QID_WIDTH-1:0];
                    pifo_out_en_d = onehot(pick_s[QID_WIDTH-1:0]);
                    state_d       = POP;
                end else begin
                    state_d = IDLE;
                end
            end
            POP: begin
                rd_en_d  = onehot(grant_q);
                to_cnt_d = '0;
                state_d  = READ;
            end
            READ: begin
                // EOP wins over a simultaneous timeout.
                if (eop_s) begin
                    state_d     = IDLE;
                    pkt_count_d = pkt_count_q + 32'd1;
                    rr_ptr_d    = next_ptr_s;
                end else if (to_cnt_q == TO_LIMIT) begin
                    state_d  = IDLE;
                    err_d    = 1'b1;
                    rr_ptr_d = next_ptr_s;
                end else begin
                    rd_en_d  = onehot(grant_q);
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            to_cnt_q      <= '0;
            pifo_out_en_q <= '0;
            rd_en_q       <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            pkt_count_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            to_cnt_q      <= to_cnt_d;
            pifo_out_en_q <= pifo_out_en_d;
            rd_en_q       <= rd_en_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    assign m_axis_ctl_pifo_out_en  = pifo_out_en_q;
    assign m_axis_ctl_buffer_rd_en = rd_en_q;
    assign m_axis_grant_id         = grant_q;
    assign m_axis_busy             = busy_q;
    assign m_axis_err_timeout      = err_q;
    assign m_axis_pkt_count        = pkt_count_q;

endmodule

// File: tb/tb_dequeue_scheduler_v0_1.sv
// Self-checking bench for dequeue_scheduler_v0_1: transaction-level round-robin
// model (pointer + packet counter) against randomized eligibility and packets.
module tb_dequeue_scheduler_v0_1;

    localparam int QN = 5;
    localparam int TO = 2048;

    logic          clk;
    logic          rst_n;
    logic [QN-1:0] pifo_empty;
    logic [QN-1:0] tx_ready;
    logic          rd_valid;
    logic          rd_last;
    logic [QN-1:0] pifo_en;
    logic [QN-1:0] rd_en;
    logic [2:0]    gid;
    logic          busy;
    logic          err;
    logic [31:0]   cnt;

    int            vec;
    int            errs;
    int            m_rr;
    logic [31:0]   m_cnt;

    dequeue_scheduler_v0_1 #(.QUEUE_NUM(QN), .QID_WIDTH(3), .TIMEOUT_CYCLES(TO)) dut (
        .axis_aclk               (clk),
        .axis_resetn             (rst_n),
        .s_axis_pifo_empty       (pifo_empty),
        .s_axis_tx_ready         (tx_ready),
        .s_axis_buffer_rd_valid  (rd_valid),
        .s_axis_buffer_rd_last   (rd_last),
        .m_axis_ctl_pifo_out_en  (pifo_en),
        .m_axis_ctl_buffer_rd_en (rd_en),
        .m_axis_grant_id         (gid),
        .m_axis_busy             (busy),
        .m_axis_err_timeout      (err),
        .m_axis_pkt_count        (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_pick(input logic [QN-1:0] e);
        for (int i = 0; i < QN; i++) begin
            if (e[(m_rr + i) % QN]) return (m_rr + i) % QN;
        end
        return -1;
    endfunction

    function automatic logic [QN-1:0] oh(input int g);
        logic [QN-1:0] one;
        one = 5'b00001;
        return one << g;
    endfunction

    task automatic set_idle_inputs();
        pifo_empty = 5'b11111;
        tx_ready   = 5'($urandom);
        rd_valid   = 1'b0;
        rd_last    = 1'b0;
    endtask

    task automatic randomize_junk();
        pifo_empty = 5'($urandom);
        tx_ready   = 5'($urandom);
    endtask

    // Presents eligibility at a negedge in IDLE; returns at the first READ negedge.
    task automatic start_packet(input logic [QN-1:0] e, output int g);
        int waited;
        pifo_empty = ~e;
        tx_ready   = e | (5'($urandom) & ~e);
        rd_valid   = 1'($urandom);
        rd_last    = 1'($urandom);
        g          = model_pick(e);
        waited     = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (pifo_en == 5'b00000 && waited < 8);
        vec++;
        if (waited != 1) begin
            errs++;
            $display("FAIL grant_latency: got %0d cycles, want 1", waited);
        end
        vec++;
        if (pifo_en !== oh(g) || gid !== 3'(g) || busy !== 1'b1 || rd_en !== 5'b00000) begin
            errs++;
            $display("FAIL pop: pifo_en=%b gid=%0d busy=%b rd_en=%b, want pifo_en=%b gid=%0d busy=1 rd_en=0",
                     pifo_en, gid, busy, rd_en, oh(g), g);
        end
        randomize_junk();
        rd_valid = 1'($urandom);
        rd_last  = 1'($urandom);
        @(negedge clk);
        vec++;
        if (rd_en !== oh(g) || pifo_en !== 5'b00000 || busy !== 1'b1) begin
            errs++;
            $display("FAIL read_start: rd_en=%b pifo_en=%b busy=%b, want rd_en=%b pifo_en=0 busy=1",
                     rd_en, pifo_en, busy, oh(g));
        end
    endtask

    // Full packet: grant, pop, `beats` beats (optionally with idle gaps), EOP.
    task automatic serve(input logic [QN-1:0] e, input int beats, input bit gaps, output int g);
        int left;
        int cycles;
        bit fire;
        start_packet(e, g);
        left   = beats;
        cycles = 0;
        while (left > 0 && cycles < 200) begin
            randomize_junk();
            rd_valid = gaps ? 1'($urandom_range(0, 2) != 0) : 1'b1;
            rd_last  = rd_valid ? (left == 1) : 1'($urandom);
            fire     = rd_valid && (left == 1);
            if (rd_valid) left--;
            cycles++;
            @(negedge clk);
            if (fire) begin
                m_cnt = m_cnt + 32'd1;
                m_rr  = (g + 1) % QN;
                vec++;
                if (rd_en !== 5'b00000 || busy !== 1'b0 || err !== 1'b0 || cnt !== m_cnt) begin
                    errs++;
                    $display("FAIL eop: rd_en=%b busy=%b err=%b cnt=%0d, want 0 0 0 cnt=%0d",
                             rd_en, busy, err, cnt, m_cnt);
                end
            end else begin
                vec++;
                if (rd_en !== oh(g) || busy !== 1'b1) begin
                    errs++;
                    $display("FAIL read_hold: rd_en=%b busy=%b, want rd_en=%b busy=1", rd_en, busy, oh(g));
                end
            end
        end
        rd_valid = 1'b0;
        rd_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle_inputs();
        repeat (3) @(negedge clk);
        vec++;
        if (pifo_en !== 5'b0 || rd_en !== 5'b0 || gid !== 3'd0 || busy !== 1'b0 || err !== 1'b0 || cnt !== 32'd0) begin
            errs++;
            $display("FAIL reset: pifo_en=%b rd_en=%b gid=%0d busy=%b err=%b cnt=%0d, want all 0",
                     pifo_en, rd_en, gid, busy, err, cnt);
        end
        rst_n = 1'b1;
        m_rr  = 0;
        m_cnt = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int g;
        int order [6] = '{0, 1, 2, 3, 4, 0};
        for (int i = 0; i < 6; i++) begin
            serve(5'b11111, 1, 1'b0, g);
            vec++;
            if (g != order[i]) begin
                errs++;
                $display("FAIL rr_order[%0d]: model grant %0d, want %0d", i, g, order[i]);
            end
        end
    endtask

    task automatic test_single_queue();
        int g;
        serve(5'b00100, 4, 1'b1, g);
        vec++;
        if (cnt !== m_cnt || gid !== 3'd2) begin
            errs++;
            $display("FAIL single_queue: cnt=%0d gid=%0d, want cnt=%0d gid=2", cnt, gid, m_cnt);
        end
    endtask

    task automatic test_wrap();
        int g;
        serve(5'b01000, 1, 1'b0, g);
        serve(5'b00011, 2, 1'b1, g);
        vec++;
        if (gid !== 3'd0) begin
            errs++;
            $display("FAIL wrap_grant: gid=%0d, want 0", gid);
        end
        serve(5'b00011, 1, 1'b0, g);
        vec++;
        if (gid !== 3'd1) begin
            errs++;
            $display("FAIL wrap_next: gid=%0d, want 1", gid);
        end
    endtask

    task automatic test_tx_not_ready();
        int g;
        pifo_empty = 5'b11101;
        tx_ready   = 5'b11101;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vec++;
            if (pifo_en !== 5'b0 || busy !== 1'b0) begin
                errs++;
                $display("FAIL no_grant: pifo_en=%b busy=%b, want 0 0", pifo_en, busy);
            end
        end
        serve(5'b00010, 3, 1'b1, g);
    endtask

    task automatic test_timeout(input bit eop_at_limit);
        int          g;
        logic [31:0] exp_cnt;
        start_packet(5'b10000, g);
        for (int i = 1; i <= TO; i++) begin
            randomize_junk();
            rd_valid = 1'($urandom);
            rd_last  = 1'b0;
            if (eop_at_limit && i == TO) begin
                rd_valid = 1'b1;
                rd_last  = 1'b1;
            end
            @(negedge clk);
            if (i < TO && (rd_en !== oh(g) || err !== 1'b0)) begin
                vec++;
                errs++;
                $display("FAIL timeout_hold: cycle %0d rd_en=%b err=%b, want rd_en=%b err=0", i, rd_en, err, oh(g));
            end
        end
        vec++;
        m_rr    = (g + 1) % QN;
        exp_cnt = eop_at_limit ? m_cnt + 32'd1 : m_cnt;
        m_cnt   = exp_cnt;
        if (err !== !eop_at_limit || rd_en !== 5'b0 || busy !== 1'b0 || cnt !== exp_cnt) begin
            errs++;
            $display("FAIL timeout_end: err=%b rd_en=%b busy=%b cnt=%0d, want err=%b rd_en=0 busy=0 cnt=%0d",
                     err, rd_en, busy, cnt, !eop_at_limit, exp_cnt);
        end
        set_idle_inputs();
        @(negedge clk);
        vec++;
        if (err !== 1'b0) begin
            errs++;
            $display("FAIL timeout_pulse: err=%b one cycle later, want 0", err);
        end
    endtask

    task automatic test_random();
        int            g;
        logic [QN-1:0] e;
        for (int i = 0; i < 25; i++) begin
            e = 5'($urandom_range(1, 31));
            serve(e, $urandom_range(1, 6), 1'b1, g);
        end
        set_idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int g;
        start_packet(5'b10000, g);
        rd_valid = 1'b1;
        rd_last  = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if (rd_en !== 5'b0 || busy !== 1'b0 || cnt !== 32'd0) begin
            errs++;
            $display("FAIL async_reset: rd_en=%b busy=%b cnt=%0d, want 0 0 0", rd_en, busy, cnt);
        end
        set_idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        m_rr  = 0;
        m_cnt = 32'd0;
        serve(5'b11111, 2, 1'b1, g);
        vec++;
        if (gid !== 3'd0 || cnt !== 32'd1) begin
            errs++;
            $display("FAIL restart: gid=%0d cnt=%0d, want gid=0 cnt=1", gid, cnt);
        end
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        rst_n = 1'b0;
        set_idle_inputs();
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_single_queue();
        test_wrap();
        test_tx_not_ready();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
